// File: rtl/imem_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared definitions for the instruction-memory load sequencer: imem geometry,
// host command encodings and the sequencer state encoding.
// ----------------------------------------------------------------------------
package imem_ctrl_pkg;

    localparam int IMEM_ADDR_W = 9;
    localparam int IMEM_DEPTH  = 512;
    localparam int IMEM_DATA_W = 32;

    // Host command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_HALT = 2'd2,
        CMD_STEP = 2'd3
    } cmd_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4,
        S_STEP   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl_if
// Bundles every non-clock signal of the load sequencer.
//   cmd_*   : host command channel (valid/ready)
//   wr_*    : program-word stream (valid/ready)
//   imem_*  : instruction-memory write port
//   fetch_* : fetch PC clear / advance enable
//   busy, done, err : status
// master = host side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    import imem_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_e           cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;

    logic              fetch_clr;
    logic              fetch_en;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, imem_we, imem_waddr, imem_wdata,
               fetch_clr, fetch_en, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, imem_we, imem_waddr, imem_wdata,
               fetch_clr, fetch_en, busy, done, err
    );

endinterface

// File: rtl/imem_wr_ptr.sv
// ----------------------------------------------------------------------------
// imem_wr_ptr
// Write pointer for an imem load: an ADDR_W pointer that wraps naturally at
// 2**ADDR_W plus an ADDR_W+1 down-counter of words still to be accepted.
//   clk, rst      : clock, asynchronous active-low reset
//   i_load        : capture i_start / i_len (start of a LOAD)
//   i_start       : first word address
//   i_len         : number of words in the LOAD
//   i_adv         : one word accepted; advance pointer, decrement count
//   o_ptr         : address for the word being accepted now
//   o_last        : the word being accepted now is the final one
// ----------------------------------------------------------------------------
module imem_wr_ptr
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remain;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_ptr    <= i_start;
            r_remain <= i_len;
        end else if (i_adv) begin
            // Pointer width equals the memory depth, so +1 wraps 511 -> 0.
            r_ptr    <= r_ptr + 1'b1;
            r_remain <= r_remain - 1'b1;
        end
    end

    assign o_ptr  = r_ptr;
    assign o_last = (r_remain == (ADDR_W+1)'(1));

endmodule

// File: rtl/imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl
// Host-side sequencer for the instruction-fetch stage and its instruction
// memory. Executes LOAD / RUN / HALT / STEP commands, streams program words
// into imem with one cycle of latency, and drives the fetch PC clear/enable.
// Fetch is never enabled while a load is in progress.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : imem_load_ctrl_if.slave (command, word stream, imem port, status)
// ----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    imem_load_ctrl_if.slave  bus
);

    localparam int LEN_W = ADDR_W + 1;

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              r_err;

    logic              w_cmd_fire;
    logic              w_wr_fire;
    logic              w_len_ok;
    logic              w_ptr_load;
    logic              w_err_set;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr;

    logic              w_cmd_ready;
    logic              w_wr_ready;
    logic              w_fetch_en;
    logic              w_fetch_clr;
    logic              w_busy;

    assign w_cmd_fire = bus.cmd_valid & w_cmd_ready;
    assign w_wr_fire  = bus.wr_valid  & w_wr_ready;
    assign w_len_ok   = (bus.cmd_len != '0) && (bus.cmd_len <= LEN_W'(DEPTH));

    imem_wr_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ptr_load),
        .i_start (bus.cmd_addr),
        .i_len   (bus.cmd_len),
        .i_adv   (w_wr_fire),
        .o_ptr   (w_ptr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_wr_fire;
            if (w_wr_fire) begin
                r_waddr <= w_ptr;
                r_wdata <= bus.wr_data;
            end
            // FLUSH lasts one cycle and carries the final write; done follows it.
            r_done  <= (r_state == S_FLUSH);
            r_err   <= w_err_set;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_ptr_load  = 1'b0;
        w_err_set   = 1'b0;
        w_cmd_ready = 1'b1;
        w_wr_ready  = 1'b0;
        w_fetch_en  = 1'b0;
        w_fetch_clr = 1'b0;
        w_busy      = 1'b0;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (w_cmd_fire) begin
                    case (bus.cmd_op)
                        CMD_LOAD: begin
                            if (w_len_ok) begin
                                w_next     = S_LOAD;
                                w_ptr_load = 1'b1;
                            end else begin
                                w_err_set  = 1'b1;
                            end
                        end
                        CMD_RUN:  w_next = S_RUN;
                        CMD_STEP: w_next = S_STEP;
                        default:  ;  // HALT while stopped is a no-op
                    endcase
                end
            end
            S_LOAD: begin
                w_cmd_ready = 1'b0;
                w_wr_ready  = 1'b1;
                w_fetch_clr = 1'b1;
                w_busy      = 1'b1;
                if (w_wr_fire && w_last)
                    w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_cmd_ready = 1'b0;
                w_busy      = 1'b1;
                w_next      = S_IDLE;
            end
            S_RUN: begin
                w_fetch_en = 1'b1;
                if (w_cmd_fire) begin
                    case (bus.cmd_op)
                        CMD_HALT:           w_next    = S_HALTED;
                        CMD_LOAD, CMD_STEP: w_err_set = 1'b1;
                        default:            ;
                    endcase
                end
            end
            S_STEP: begin
                w_cmd_ready = 1'b0;
                w_fetch_en  = 1'b1;
                w_next      = S_HALTED;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.fetch_en   = w_fetch_en;
    assign bus.fetch_clr  = w_fetch_clr;
    assign bus.busy       = w_busy;
    assign bus.imem_we    = r_we;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = r_wdata;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule
